// File: rtl/ddr_iod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_iod_pkg
// Brief    : Shared encodings for the IOD delay-line controller.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_iod_pkg;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_SET  = 2'b11;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_CLAMPED   = 2'b01;
    localparam logic [1:0] ST_IOD_RANGE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_MOVE    = 3'd2,
        S_SETTLE  = 3'd3,
        S_LOAD    = 3'd4,
        S_LSETTLE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr_iod_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_iod_step_timer
// Brief    : Loadable settle down-counter; last is high in the final settle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_iod_step_timer import ddr_iod_pkg::*; #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Loaded during the pulse cycle so the first settle cycle already sees the full count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_reload;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign last = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ddr_iod_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr_iod_delay_ctrl
// Brief    : Multi-lane IOD delay-line sequencer with shadow tap counts.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_iod_delay_ctrl import ddr_iod_pkg::*; #(
    parameter int NUM_LANES     = 8,
    parameter int TAP_WIDTH     = 8,
    parameter int MAX_TAP       = 255,
    parameter int DEFAULT_TAP   = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int LANE_IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                           FAB_CLK,
    input  logic                           SYNC_RST,
    input  logic                           REQ_VALID,
    output logic                           REQ_READY,
    input  logic [LANE_IDX_W-1:0]          REQ_LANE,
    input  logic [1:0]                     REQ_CMD,
    input  logic [TAP_WIDTH-1:0]           REQ_ARG,
    output logic                           DONE,
    output logic [1:0]                     DONE_STATUS,
    output logic                           BUSY,
    output logic [NUM_LANES*TAP_WIDTH-1:0] TAP_VALUE,
    output logic [NUM_LANES-1:0]           DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]           DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]           DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0]           DELAY_LINE_OUT_OF_RANGE
);

    localparam logic [TAP_WIDTH-1:0]  c_max_tap     = TAP_WIDTH'(MAX_TAP);
    localparam logic [TAP_WIDTH-1:0]  c_default_tap = TAP_WIDTH'(DEFAULT_TAP);
    localparam logic [LANE_IDX_W:0]   c_num_lanes   = (LANE_IDX_W+1)'(NUM_LANES);

    state_t                r_state;
    logic [LANE_IDX_W-1:0] r_lane;
    logic                  r_dir;
    logic [TAP_WIDTH-1:0]  r_steps;
    logic [1:0]            r_req_status;
    logic [TAP_WIDTH-1:0]  r_tap [NUM_LANES];
    logic [NUM_LANES-1:0]  r_move;
    logic [NUM_LANES-1:0]  r_dir_out;
    logic [NUM_LANES-1:0]  r_load;
    logic                  r_done;
    logic [1:0]            r_done_status;

    logic                  w_lane_ok;
    logic [LANE_IDX_W-1:0] w_lane_sel;
    logic [TAP_WIDTH-1:0]  w_tap_cur;
    logic [TAP_WIDTH-1:0]  w_headroom;
    logic [TAP_WIDTH-1:0]  w_target;
    logic [TAP_WIDTH-1:0]  w_steps;
    logic                  w_dir;
    logic                  w_clamped;
    logic                  w_timer_load;
    logic                  w_settle_last;

    assign w_lane_ok  = ({1'b0, REQ_LANE} < c_num_lanes);
    assign w_lane_sel = w_lane_ok ? REQ_LANE : '0;

    // Step count and direction from the selected lane's current shadow tap.
    always_comb begin
        w_tap_cur  = r_tap[w_lane_sel];
        w_headroom = c_max_tap - w_tap_cur;
        w_target   = '0;
        w_steps    = '0;
        w_dir      = 1'b0;
        w_clamped  = 1'b0;
        case (REQ_CMD)
            CMD_INC: begin
                w_dir = 1'b1;
                if (REQ_ARG > w_headroom) begin
                    w_clamped = 1'b1;
                    w_steps   = w_headroom;
                end else begin
                    w_steps = REQ_ARG;
                end
            end
            CMD_DEC: begin
                if (REQ_ARG > w_tap_cur) begin
                    w_clamped = 1'b1;
                    w_steps   = w_tap_cur;
                end else begin
                    w_steps = REQ_ARG;
                end
            end
            CMD_SET: begin
                w_clamped = ({1'b0, REQ_ARG} > {1'b0, c_max_tap});
                w_target  = w_clamped ? c_max_tap : REQ_ARG;
                w_dir     = (w_target > w_tap_cur);
                w_steps   = w_dir ? (w_target - w_tap_cur) : (w_tap_cur - w_target);
            end
            default: ;
        endcase
    end

    assign w_timer_load = (r_state == S_MOVE) || (r_state == S_LOAD);

    ddr_iod_step_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_step_timer (
        .clk  (FAB_CLK),
        .rst  (SYNC_RST),
        .load (w_timer_load),
        .last (w_settle_last)
    );

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_state       <= S_IDLE;
            r_lane        <= '0;
            r_dir         <= 1'b0;
            r_steps       <= '0;
            r_req_status  <= ST_OK;
            r_move        <= '0;
            r_dir_out     <= '0;
            r_load        <= '0;
            r_done        <= 1'b0;
            r_done_status <= ST_OK;
            for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= c_default_tap;
        end else begin
            r_move <= '0;
            r_load <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        r_lane       <= w_lane_sel;
                        r_dir        <= w_dir;
                        r_steps      <= w_steps;
                        r_req_status <= w_clamped ? ST_CLAMPED : ST_OK;
                        if (!w_lane_ok) begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_done_status <= ST_CLAMPED;
                        end else if (REQ_CMD == CMD_LOAD) begin
                            r_state              <= S_LOAD;
                            r_load[w_lane_sel]   <= 1'b1;
                        end else if (w_steps == '0) begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_done_status <= w_clamped ? ST_CLAMPED : ST_OK;
                        end else begin
                            r_state               <= S_SETUP;
                            r_dir_out[w_lane_sel] <= w_dir;
                        end
                    end
                end
                S_SETUP: begin
                    r_state        <= S_MOVE;
                    r_move[r_lane] <= 1'b1;
                end
                S_MOVE: begin
                    r_state       <= S_SETTLE;
                    r_steps       <= r_steps - 1'b1;
                    r_tap[r_lane] <= r_dir ? (r_tap[r_lane] + 1'b1) : (r_tap[r_lane] - 1'b1);
                end
                S_SETTLE: begin
                    if (w_settle_last) begin
                        // A range flag from the IOD ends the request even with steps left.
                        if (DELAY_LINE_OUT_OF_RANGE[r_lane]) begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_done_status <= ST_IOD_RANGE;
                            r_dir_out     <= '0;
                        end else if (r_steps != '0) begin
                            r_state        <= S_MOVE;
                            r_move[r_lane] <= 1'b1;
                        end else begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_done_status <= r_req_status;
                            r_dir_out     <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    r_state       <= S_LSETTLE;
                    r_tap[r_lane] <= c_default_tap;
                end
                S_LSETTLE: begin
                    if (w_settle_last) begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_done_status <= ST_OK;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap_out
        assign TAP_VALUE[g*TAP_WIDTH +: TAP_WIDTH] = r_tap[g];
    end

    assign REQ_READY            = (r_state == S_IDLE) && !SYNC_RST;
    assign BUSY                 = (r_state != S_IDLE);
    assign DONE                 = r_done;
    assign DONE_STATUS          = r_done_status;
    assign DELAY_LINE_MOVE      = r_move;
    assign DELAY_LINE_DIRECTION = r_dir_out;
    assign DELAY_LINE_LOAD      = r_load;

endmodule
`default_nettype wire

// File: tb/tb_ddr_iod_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_iod_delay_ctrl
// Brief    : Scoreboard bench for ddr_iod_delay_ctrl with directed requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_iod_delay_ctrl;
    import ddr_iod_pkg::*;

    logic        FAB_CLK = 1'b0;
    logic        SYNC_RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [2:0]  REQ_LANE;
    logic [1:0]  REQ_CMD;
    logic [7:0]  REQ_ARG;
    logic        DONE;
    logic [1:0]  DONE_STATUS;
    logic        BUSY;
    logic [63:0] TAP_VALUE;
    logic [7:0]  DELAY_LINE_MOVE;
    logic [7:0]  DELAY_LINE_DIRECTION;
    logic [7:0]  DELAY_LINE_LOAD;
    logic [7:0]  DELAY_LINE_OUT_OF_RANGE;

    ddr_iod_delay_ctrl #(
        .NUM_LANES(8), .TAP_WIDTH(8), .MAX_TAP(255), .DEFAULT_TAP(1), .SETTLE_CYCLES(4)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .SYNC_RST                (SYNC_RST),
        .REQ_VALID               (REQ_VALID),
        .REQ_READY               (REQ_READY),
        .REQ_LANE                (REQ_LANE),
        .REQ_CMD                 (REQ_CMD),
        .REQ_ARG                 (REQ_ARG),
        .DONE                    (DONE),
        .DONE_STATUS             (DONE_STATUS),
        .BUSY                    (BUSY),
        .TAP_VALUE               (TAP_VALUE),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int cyc = 0;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [1:0]  st;
        int          moves;
        int          loads;
        int          lat;
        logic [63:0] taps;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        m_it;
    logic [7:0]  mtap [8];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cur_lane = 0;
    bit          cur_dir  = 1'b0;
    int          mv_cnt = 0, ld_cnt = 0, bad = 0, last_mv = -100;
    logic [7:0]  sel;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_taps();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mtap[i];
        return v;
    endfunction

    // Monitor: tracks IOD pulses and checks each DONE against the queued expectation.
    always @(negedge FAB_CLK) begin
        if (SYNC_RST) begin
            mv_cnt = 0; ld_cnt = 0; bad = 0; last_mv = -100;
        end else begin
            sel = 8'b1 << cur_lane;
            if (DELAY_LINE_MOVE != 8'h00) begin
                mv_cnt++;
                if (DELAY_LINE_MOVE != sel || DELAY_LINE_DIRECTION != (cur_dir ? sel : 8'h00)
                    || (cyc - last_mv) < 5) bad++;
                last_mv = cyc;
            end
            if (DELAY_LINE_LOAD != 8'h00) begin
                ld_cnt++;
                if (DELAY_LINE_LOAD != sel) bad++;
            end
            if ((DELAY_LINE_DIRECTION & ~sel) != 8'h00) bad++;
            if (DONE) begin
                if (DELAY_LINE_DIRECTION != 8'h00) bad++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got DONE status %0d expected no DONE", DONE_STATUS);
                end else begin
                    m_it = q.pop_front();
                    chk({m_it.name, "_status"}, DONE_STATUS, m_it.st);
                    chk({m_it.name, "_latency"}, cyc - m_it.acc + 1, m_it.lat);
                    chk({m_it.name, "_taps"}, TAP_VALUE, m_it.taps);
                    chk({m_it.name, "_moves"}, mv_cnt, m_it.moves);
                    chk({m_it.name, "_loads"}, ld_cnt, m_it.loads);
                    chk({m_it.name, "_pulse_errors"}, bad, 0);
                end
                mv_cnt = 0; ld_cnt = 0; bad = 0;
            end
        end
    end

    task automatic send(input string nm, input int lane, input logic [1:0] cmd, input int arg,
                        input bit dir, input logic [1:0] st, input int moves, input int loads,
                        input int lat, input int tap, input bit push, input bit hold);
        exp_t it;
        @(negedge FAB_CLK);
        cur_lane  = lane;
        cur_dir   = dir;
        REQ_LANE  = 3'(lane);
        REQ_CMD   = cmd;
        REQ_ARG   = 8'(arg);
        REQ_VALID = 1'b1;
        if (!REQ_READY) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_ready: got 0 expected 1", nm);
        end
        if (push) begin
            mtap[lane] = 8'(tap);
            it.name  = nm;
            it.st    = st;
            it.moves = moves;
            it.loads = loads;
            it.lat   = lat;
            it.taps  = pack_taps();
            it.acc   = cyc + 1;
            q.push_back(it);
        end
        if (!hold) begin
            @(negedge FAB_CLK);
            REQ_VALID = 1'b0;
        end
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 2000; i++) begin
            @(negedge FAB_CLK);
            if (q.size() == 0) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: got no DONE expected DONE within 2000 cycles", nm);
        q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int rdy_bad;
        bit seen;
        for (int i = 0; i < 8; i++) mtap[i] = 8'd1;
        SYNC_RST = 1'b1;
        REQ_VALID = 1'b0;
        REQ_LANE = '0;
        REQ_CMD = CMD_LOAD;
        REQ_ARG = '0;
        DELAY_LINE_OUT_OF_RANGE = '0;
        repeat (3) @(negedge FAB_CLK);
        chk("rst_ready_low", REQ_READY, 0);
        SYNC_RST = 1'b0;
        #1;
        chk("rst_ready", REQ_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_status", DONE_STATUS, 0);
        chk("rst_iod", {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD}, 0);
        chk("rst_taps", TAP_VALUE, 64'h0101_0101_0101_0101);

        send("inc3x4", 3, CMD_INC, 4, 1, ST_OK, 4, 0, 22, 5, 1, 0);      wait_done("inc3x4");
        send("dec3x2", 3, CMD_DEC, 2, 0, ST_OK, 2, 0, 12, 3, 1, 0);      wait_done("dec3x2");
        send("set0to0", 0, CMD_SET, 0, 0, ST_OK, 1, 0, 7, 0, 1, 0);      wait_done("set0to0");
        send("dec0x3", 0, CMD_DEC, 3, 0, ST_CLAMPED, 0, 0, 1, 0, 1, 0);  wait_done("dec0x3");

        send("inc2oor", 2, CMD_INC, 10, 1, ST_IOD_RANGE, 2, 0, 12, 3, 1, 0);
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 2; i++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE[2]) cnt++;
        end
        DELAY_LINE_OUT_OF_RANGE[2] = 1'b1;
        wait_done("inc2oor");
        DELAY_LINE_OUT_OF_RANGE = '0;

        send("set7to200", 7, CMD_SET, 200, 1, ST_OK, 199, 0, 997, 200, 1, 0); wait_done("set7to200");
        send("load7", 7, CMD_LOAD, 0, 0, ST_OK, 0, 1, 6, 1, 1, 0);            wait_done("load7");
        send("set6to253", 6, CMD_SET, 253, 1, ST_OK, 252, 0, 1262, 253, 1, 0); wait_done("set6to253");
        send("inc6clamp", 6, CMD_INC, 10, 1, ST_CLAMPED, 2, 0, 12, 255, 1, 0); wait_done("inc6clamp");
        send("set6same", 6, CMD_SET, 255, 0, ST_OK, 0, 0, 1, 255, 1, 0);      wait_done("set6same");

        // Valid held while busy, other lanes flagging out of range.
        DELAY_LINE_OUT_OF_RANGE = 8'hEF;
        send("hold4", 4, CMD_INC, 2, 1, ST_OK, 2, 0, 12, 3, 1, 1);
        rdy_bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge FAB_CLK);
            if (REQ_READY) rdy_bad++;
            if (DONE) begin
                REQ_VALID = 1'b0;
                seen = 1'b1;
                break;
            end
            REQ_LANE = REQ_LANE + 3'd1;
        end
        chk("hold_ready_low", rdy_bad, 0);
        chk("hold_done_seen", seen, 1);
        wait_done("hold4");
        DELAY_LINE_OUT_OF_RANGE = '0;
        repeat (10) @(negedge FAB_CLK);

        // Reset in the middle of a settle interval.
        send("rstmid", 1, CMD_SET, 50, 1, ST_OK, 0, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstmid_move_seen", seen, 1);
        repeat (2) @(negedge FAB_CLK);
        SYNC_RST = 1'b1;
        @(negedge FAB_CLK);
        chk("rstmid_iod", {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD}, 0);
        chk("rstmid_done", DONE, 0);
        chk("rstmid_busy", BUSY, 0);
        chk("rstmid_taps", TAP_VALUE, 64'h0101_0101_0101_0101);
        chk("rstmid_ready_low", REQ_READY, 0);
        @(negedge FAB_CLK);
        SYNC_RST = 1'b0;
        #1;
        chk("rstmid_ready", REQ_READY, 1);
        for (int i = 0; i < 8; i++) mtap[i] = 8'd1;
        repeat (30) @(negedge FAB_CLK);

        send("inc1after", 1, CMD_INC, 1, 1, ST_OK, 1, 0, 7, 2, 1, 0);  wait_done("inc1after");
        repeat (20) @(negedge FAB_CLK);
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
